receiver_packetiser: RTL and testbench
======================================

// Module: receiver_packetiser
// PURPOSE
//  Multi-channel successor to the single-ADC receiver packet framer. Sits between ADC front-ends and
//  the DSP packet stream. Arms on a trigger that arrives from the control-clock domain. Captures a
//  run-time-programmable number of sample sets. Serialises NUM_CH channels per set into one framed stream.
//  Adds an offset-binary conversion mode and counters for overruns and missed triggers.
// PARAMETERS
//  NUM_CH      4     channels per sample set (1..16)
//  W           14    sample width, bits
//  LEN_W       16    width of packet-length register
//  OFFSET_BIN  1     1: invert sample MSB on output (two's complement -> offset binary); 0: pass through
// PORTS
//  ipDspClk          in   1          DSP clock; all logic on rising edge
//  Reset             in   1          synchronous, active-high reset
//  ipTrigger         in   1          packet trigger from control domain; async to ipDspClk
//  ipLength          in   LEN_W      sample sets per packet; latched at trigger acceptance
//  ipData            in   NUM_CH*W   channel k at bits [k*W +: W]
//  ipValid           in   1          one-cycle strobe: ipData holds a new sample set
//  opData            out  W          serialised sample
//  opChannel         out  4          channel index of opData
//  opSoP             out  1          first beat of packet
//  opEoP             out  1          last beat of packet
//  opValid           out  1          beat qualifier; no backpressure
//  opBusy            out  1          packet in progress (state != Idle)
//  opOverruns        out  16         count of dropped sample sets; saturates at 16'hFFFF
//  opMissedTriggers  out  16         count of ignored triggers; saturates at 16'hFFFF
// BEHAVIOUR
//  Reset: all outputs 0, both counters 0, state Idle, synchroniser flops 0.
//  Trigger path: 2-flop synchroniser, then rising-edge detect. The edge pulse appears 3 cycles after ipTrigger rises.
//  States: Idle, Sampling.
//   Idle -> Sampling on an edge pulse with ipLength != 0. Latch len = ipLength; set n = 0.
//   Edge pulse with ipLength == 0: stay in Idle; opMissedTriggers increments.
//   Edge pulse while in Sampling: ignored; opMissedTriggers increments.
//   Sampling -> Idle in the cycle after the EoP beat.
//  Capture: in Sampling, an ipValid with the serialiser free loads all NUM_CH samples into the holding register.
//  Serialise: beats go out on consecutive cycles, channel 0 first.
//   ipValid at cycle t -> channel k beat (opValid = 1) at cycle t+1+k.
//  Overrun: ipValid arriving while the serialiser still holds beats.
//   The set is dropped, opOverruns increments, and n does not advance.
//  ipValid in Idle is ignored and is not counted.
//  Framing:
//   opSoP = 1 only on the beat with n == 0 and channel 0.
//   opEoP = 1 only on the beat with n == len-1 and channel NUM_CH-1.
//   Exactly len*NUM_CH beats are produced per packet.
//  Edge cases:
//   len == 1 with NUM_CH == 1: SoP and EoP assert on the same beat.
//   n counts 0..len-1 with no wrap; len = 2^LEN_W-1 must work.
//  Data: opData = OFFSET_BIN ? {~s[W-1], s[W-2:0]} : s. opData, opChannel, opSoP, opEoP are 0 when opValid = 0.
//  Simultaneous events:
//   Trigger edge and ipValid in the same Idle cycle: that sample set is not captured.
//   The EoP-cycle trigger edge is counted as missed.
//  Reset mid-packet: next cycle opValid = 0 and no EoP is emitted. The partial packet is abandoned.
//  Counters hold their value until Reset; they do not wrap.
// TESTING
//  1. NUM_CH=4, len=3, ipValid every 8 cycles -> 12 beats, channels 0..3 repeating; SoP on beat 0, EoP on beat 11; opBusy drops after.
//  2. ipValid every 2 cycles with NUM_CH=4, len=4 -> every second set dropped; opOverruns increments once per dropped set; packet still 16 beats.
//  3. Second trigger mid-packet, plus a trigger with ipLength=0 -> opMissedTriggers = 2; the first packet is unaffected.
//  4. ch0 sample = 14'h2000, OFFSET_BIN=1 -> opData = 14'h0000; OFFSET_BIN=0 -> 14'h2000.
//  5. Reset asserted on beat 5 of 12 -> opValid = 0 next cycle, no EoP, counters 0; a new trigger then yields a full packet with SoP.
//  6. NUM_CH=1, len=1 -> single beat with SoP = EoP = 1; trigger-to-Sampling latency of 3 cycles checked.

Source files
------------

// File: rtl/receiver_packetiser_if.sv
// Framed sample stream leaving the packetiser: one serialised sample per beat,
// qualified by opValid, with channel index and start/end-of-packet markers.
interface receiver_packetiser_if #(
  parameter int W = 14
);
  logic [W-1:0] opData;
  logic [3:0]   opChannel;
  logic         opSoP;
  logic         opEoP;
  logic         opValid;

  modport master (output opData, opChannel, opSoP, opEoP, opValid);
  modport slave  (input  opData, opChannel, opSoP, opEoP, opValid);
endinterface

// File: rtl/receiver_packetiser.sv
// Multi-channel receiver packet framer: arms on a synchronised trigger, captures
// a programmable number of sample sets and serialises NUM_CH channels per set.
module receiver_packetiser #(
  parameter int NUM_CH     = 4,
  parameter int W          = 14,
  parameter int LEN_W      = 16,
  parameter int OFFSET_BIN = 1
) (
  input  logic                  ipDspClk,
  input  logic                  Reset,
  input  logic                  ipTrigger,
  input  logic [LEN_W-1:0]      ipLength,
  input  logic [NUM_CH*W-1:0]   ipData,
  input  logic                  ipValid,
  receiver_packetiser_if.master pkt,
  output logic                  opBusy,
  output logic [15:0]           opOverruns,
  output logic [15:0]           opMissedTriggers
);

  typedef enum logic {Idle, Sampling} state_t;

  localparam logic [3:0]   LastCh  = 4'(NUM_CH - 1);
  localparam logic [W-1:0] MsbMask = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] DataXor = (OFFSET_BIN != 0) ? MsbMask : '0;

  state_t               state, stateNext;
  logic                 trigMeta, trigSync, trigPrev, trigEdge;
  logic [LEN_W-1:0]     len, setCount, curSet;
  logic [NUM_CH*W-1:0]  holdReg;
  logic [3:0]           chan;
  logic                 serActive, lastChan, serFree, eop;
  logic                 capture, overrun, accept, missed;

  always_comb begin
    trigEdge  = trigSync & ~trigPrev;
    lastChan  = (chan == LastCh);
    // The serialiser can take a new set on the cycle its last beat goes out.
    serFree   = !serActive || lastChan;
    eop       = serActive && lastChan && (curSet == len - LEN_W'(1));
    capture   = (state == Sampling) && ipValid && serFree  && (setCount != len);
    overrun   = (state == Sampling) && ipValid && !serFree && (setCount != len);
    accept    = (state == Idle) && trigEdge && (ipLength != '0);
    missed    = trigEdge && !accept;

    stateNext = state;
    case (state)
      Idle:     if (accept) stateNext = Sampling;
      Sampling: if (eop)    stateNext = Idle;
      default:              stateNext = Idle;
    endcase
  end

  always_ff @(posedge ipDspClk) begin
    if (Reset) begin
      state            <= Idle;
      trigMeta         <= 1'b0;
      trigSync         <= 1'b0;
      trigPrev         <= 1'b0;
      len              <= '0;
      setCount         <= '0;
      curSet           <= '0;
      holdReg          <= '0;
      chan             <= '0;
      serActive        <= 1'b0;
      opOverruns       <= '0;
      opMissedTriggers <= '0;
    end else begin
      trigMeta <= ipTrigger;
      trigSync <= trigMeta;
      trigPrev <= trigSync;
      state    <= stateNext;

      if (accept) begin
        len      <= ipLength;
        setCount <= '0;
      end

      if (capture) begin
        holdReg   <= ipData;
        curSet    <= setCount;
        setCount  <= setCount + LEN_W'(1);
        chan      <= '0;
        serActive <= 1'b1;
      end else if (serActive) begin
        holdReg <= holdReg >> W;
        if (lastChan) begin
          chan      <= '0;
          serActive <= 1'b0;
        end else begin
          chan <= chan + 4'd1;
        end
      end

      if (overrun && opOverruns != '1)
        opOverruns <= opOverruns + 16'd1;
      if (missed && opMissedTriggers != '1)
        opMissedTriggers <= opMissedTriggers + 16'd1;
    end
  end

  always_comb begin
    pkt.opValid   = serActive;
    pkt.opData    = serActive ? (holdReg[W-1:0] ^ DataXor) : '0;
    pkt.opChannel = serActive ? chan : '0;
    pkt.opSoP     = serActive && (chan == '0) && (curSet == '0);
    pkt.opEoP     = eop;
    opBusy        = (state == Sampling);
  end

endmodule

// File: tb/tb_receiver_packetiser.sv
// Directed bench for receiver_packetiser: three instances (4-ch offset-binary,
// 4-ch pass-through, 1-ch) share one stimulus; each task checks its own scenario.
module tb_receiver_packetiser;
  localparam int W   = 14;
  localparam int NCH = 4;
  localparam int LW  = 16;

  logic            ipDspClk = 1'b0;
  logic            Reset = 1'b1;
  logic            ipTrigger = 1'b0;
  logic            ipValid = 1'b0;
  logic [LW-1:0]   ipLength = '0;
  logic [NCH*W-1:0] ipData = '0;
  logic            busy4, busyRaw, busy1;
  logic [15:0]     ovr4, mis4, ovrRaw, misRaw, ovr1, mis1;

  int tests = 0;
  int fails = 0;
  logic [19:0] q4[$];
  int dirty4 = 0;

  receiver_packetiser_if #(.W(W)) pkt4 ();
  receiver_packetiser_if #(.W(W)) pktRaw ();
  receiver_packetiser_if #(.W(W)) pkt1 ();

  receiver_packetiser #(.NUM_CH(NCH), .W(W), .LEN_W(LW), .OFFSET_BIN(1)) dut4 (
    .ipDspClk(ipDspClk), .Reset(Reset), .ipTrigger(ipTrigger), .ipLength(ipLength),
    .ipData(ipData), .ipValid(ipValid), .pkt(pkt4), .opBusy(busy4),
    .opOverruns(ovr4), .opMissedTriggers(mis4));

  receiver_packetiser #(.NUM_CH(NCH), .W(W), .LEN_W(LW), .OFFSET_BIN(0)) dutRaw (
    .ipDspClk(ipDspClk), .Reset(Reset), .ipTrigger(ipTrigger), .ipLength(ipLength),
    .ipData(ipData), .ipValid(ipValid), .pkt(pktRaw), .opBusy(busyRaw),
    .opOverruns(ovrRaw), .opMissedTriggers(misRaw));

  receiver_packetiser #(.NUM_CH(1), .W(W), .LEN_W(LW), .OFFSET_BIN(1)) dut1 (
    .ipDspClk(ipDspClk), .Reset(Reset), .ipTrigger(ipTrigger), .ipLength(ipLength),
    .ipData(ipData[W-1:0]), .ipValid(ipValid), .pkt(pkt1), .opBusy(busy1),
    .opOverruns(ovr1), .opMissedTriggers(mis1));

  always #5 ipDspClk = ~ipDspClk;

  always @(negedge ipDspClk) begin
    if (pkt4.opValid === 1'b1)
      q4.push_back({pkt4.opData, pkt4.opChannel, pkt4.opSoP, pkt4.opEoP});
    else if ({pkt4.opData, pkt4.opChannel, pkt4.opSoP, pkt4.opEoP} != '0)
      dirty4++;
  end

  function automatic logic [W-1:0] sampleVal(int s, int k);
    return W'(s * 64 + k * 4 + 1);
  endfunction

  function automatic logic [NCH*W-1:0] packSet(int s);
    logic [NCH*W-1:0] v;
    for (int k = 0; k < NCH; k++) v[k*W +: W] = sampleVal(s, k);
    return v;
  endfunction

  function automatic logic [19:0] expBeat(int s, int k, logic sop, logic eop);
    return {sampleVal(s, k) ^ 14'h2000, 4'(k), sop, eop};
  endfunction

  task automatic tick();
    @(posedge ipDspClk); #1;
  endtask

  task automatic sendSet(input logic [NCH*W-1:0] d);
    @(posedge ipDspClk); #1;
    ipData  = d;
    ipValid = 1'b1;
    @(posedge ipDspClk); #1;
    ipValid = 1'b0;
  endtask

  task automatic pulseTrigger();
    @(posedge ipDspClk); #1;
    ipTrigger = 1'b1;
    repeat (4) @(posedge ipDspClk);
    #1 ipTrigger = 1'b0;
  endtask

  task automatic doReset();
    Reset = 1'b1; ipTrigger = 1'b0; ipValid = 1'b0;
    repeat (3) @(posedge ipDspClk);
    #1 Reset = 1'b0;
    q4.delete();
    dirty4 = 0;
  endtask

  task automatic waitIdle(input int maxCycles, input string name);
    for (int i = 0; i < maxCycles && busy4 !== 1'b0; i++) tick();
    tests++;
    if (busy4 !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle_timeout: busy=%b want 0", name, busy4);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (2) @(posedge ipDspClk); #1;
    tests++;
    if ({busy4, ovr4, mis4, pkt4.opValid, pkt4.opData, pkt4.opSoP, pkt4.opEoP} !== '0) begin
      fails++;
      $display("FAIL reset_state: busy=%b ovr=%h mis=%h valid=%b data=%h want all 0",
               busy4, ovr4, mis4, pkt4.opValid, pkt4.opData);
    end
    #1 Reset = 1'b0;
  endtask

  task automatic test_packet();
    doReset();
    ipLength = 16'd3;
    pulseTrigger();
    tests++;
    if (busy4 !== 1'b1) begin fails++; $display("FAIL t1_busy: got %b want 1", busy4); end
    for (int s = 0; s < 3; s++) begin
      sendSet(packSet(s));
      repeat (6) @(posedge ipDspClk);
    end
    waitIdle(40, "t1");
    tests++;
    if (q4.size() !== 12) begin fails++; $display("FAIL t1_beats: got %0d want 12", q4.size()); end
    for (int i = 0; i < 12 && i < q4.size(); i++) begin
      tests++;
      if (q4[i] !== expBeat(i / 4, i % 4, i == 0, i == 11)) begin
        fails++;
        $display("FAIL t1_beat%0d: got %h want %h", i, q4[i], expBeat(i / 4, i % 4, i == 0, i == 11));
      end
    end
    tests++;
    if ({ovr4, mis4} !== 32'd0) begin fails++; $display("FAIL t1_counters: got %h/%h want 0/0", ovr4, mis4); end
  endtask

  task automatic test_overrun();
    doReset();
    ipLength = 16'd4;
    pulseTrigger();
    for (int s = 0; s < 7; s++) sendSet(packSet(s));
    waitIdle(40, "t2");
    tests++;
    if (ovr4 !== 16'd3) begin fails++; $display("FAIL t2_overruns: got %0d want 3", ovr4); end
    tests++;
    if (q4.size() !== 16) begin fails++; $display("FAIL t2_beats: got %0d want 16", q4.size()); end
    for (int i = 0; i < 16 && i < q4.size(); i++) begin
      tests++;
      if (q4[i] !== expBeat(2 * (i / 4), i % 4, i == 0, i == 15)) begin
        fails++;
        $display("FAIL t2_beat%0d: got %h want %h", i, q4[i], expBeat(2 * (i / 4), i % 4, i == 0, i == 15));
      end
    end
  endtask

  task automatic test_missed();
    doReset();
    ipLength = 16'd2;
    pulseTrigger();
    sendSet(packSet(0));
    pulseTrigger();
    sendSet(packSet(1));
    waitIdle(40, "t3");
    ipLength = 16'd0;
    pulseTrigger();
    repeat (3) tick();
    tests++;
    if (mis4 !== 16'd2) begin fails++; $display("FAIL t3_missed: got %0d want 2", mis4); end
    tests++;
    if (busy4 !== 1'b0) begin fails++; $display("FAIL t3_len0_busy: got %b want 0", busy4); end
    tests++;
    if (q4.size() !== 8) begin fails++; $display("FAIL t3_beats: got %0d want 8", q4.size()); end
    for (int i = 0; i < 8 && i < q4.size(); i++) begin
      tests++;
      if (q4[i] !== expBeat(i / 4, i % 4, i == 0, i == 7)) begin
        fails++;
        $display("FAIL t3_beat%0d: got %h want %h", i, q4[i], expBeat(i / 4, i % 4, i == 0, i == 7));
      end
    end
  endtask

  task automatic test_offset();
    logic [NCH*W-1:0] d;
    doReset();
    ipLength = 16'd1;
    pulseTrigger();
    tests++;
    if (busyRaw !== 1'b1) begin fails++; $display("FAIL t4_raw_busy: got %b want 1", busyRaw); end
    d = '0;
    d[0 +: W] = 14'h2000;
    d[W +: W] = 14'h1234;
    sendSet(d);
    tests++;
    if (pkt4.opData !== 14'h0000) begin fails++; $display("FAIL t4_ob_ch0: got %h want 0000", pkt4.opData); end
    tests++;
    if (pktRaw.opData !== 14'h2000) begin fails++; $display("FAIL t4_raw_ch0: got %h want 2000", pktRaw.opData); end
    tick();
    tests++;
    if (pkt4.opData !== 14'h3234) begin fails++; $display("FAIL t4_ob_ch1: got %h want 3234", pkt4.opData); end
    tests++;
    if (pktRaw.opData !== 14'h1234) begin fails++; $display("FAIL t4_raw_ch1: got %h want 1234", pktRaw.opData); end
    waitIdle(20, "t4");
    tests++;
    if ({ovrRaw, misRaw} !== 32'd0) begin fails++; $display("FAIL t4_raw_counters: got %h/%h want 0/0", ovrRaw, misRaw); end
  endtask

  task automatic test_reset_mid();
    int eops;
    doReset();
    ipLength = 16'd0;
    pulseTrigger();
    ipLength = 16'd3;
    pulseTrigger();
    sendSet(packSet(0));
    sendSet(packSet(99));
    repeat (6) tick();
    sendSet(packSet(1));
    tick();
    tests++;
    if ({pkt4.opValid, pkt4.opChannel} !== 5'b1_0001) begin
      fails++; $display("FAIL t5_beat5: valid=%b ch=%0d want 1/1", pkt4.opValid, pkt4.opChannel);
    end
    tests++;
    if ({ovr4, mis4} !== {16'd1, 16'd1}) begin fails++; $display("FAIL t5_pre_counters: got %0d/%0d want 1/1", ovr4, mis4); end
    Reset = 1'b1;
    tick();
    tests++;
    if ({pkt4.opValid, busy4, ovr4, mis4} !== '0) begin
      fails++; $display("FAIL t5_after_reset: valid=%b busy=%b ovr=%0d mis=%0d want 0", pkt4.opValid, busy4, ovr4, mis4);
    end
    Reset = 1'b0;
    eops = 0;
    foreach (q4[i]) eops += int'(q4[i][0]);
    tests++;
    if (q4.size() !== 6 || eops !== 0) begin fails++; $display("FAIL t5_partial: beats=%0d eops=%0d want 6/0", q4.size(), eops); end
    q4.delete();
    ipLength = 16'd3;
    pulseTrigger();
    for (int s = 0; s < 3; s++) begin
      sendSet(packSet(s));
      repeat (6) @(posedge ipDspClk);
    end
    waitIdle(40, "t5");
    tests++;
    if (q4.size() !== 12) begin fails++; $display("FAIL t5_beats: got %0d want 12", q4.size()); end
    for (int i = 0; i < 12 && i < q4.size(); i++) begin
      tests++;
      if (q4[i] !== expBeat(i / 4, i % 4, i == 0, i == 11)) begin
        fails++;
        $display("FAIL t5_beat%0d: got %h want %h", i, q4[i], expBeat(i / 4, i % 4, i == 0, i == 11));
      end
    end
  endtask

  task automatic test_single();
    doReset();
    ipLength = 16'd1;
    @(posedge ipDspClk); #1;
    ipTrigger = 1'b1;
    repeat (2) @(posedge ipDspClk); #1;
    tests++;
    if (busy1 !== 1'b0) begin fails++; $display("FAIL t6_latency_early: busy=%b want 0", busy1); end
    tick();
    tests++;
    if (busy1 !== 1'b1) begin fails++; $display("FAIL t6_latency: busy=%b want 1", busy1); end
    tick();
    ipTrigger = 1'b0;
    sendSet(packSet(7));
    tests++;
    if ({pkt1.opValid, pkt1.opSoP, pkt1.opEoP, pkt1.opChannel, pkt1.opData} !==
        {3'b111, 4'd0, sampleVal(7, 0) ^ 14'h2000}) begin
      fails++;
      $display("FAIL t6_beat: valid=%b sop=%b eop=%b ch=%0d data=%h want 1/1/1/0/%h",
               pkt1.opValid, pkt1.opSoP, pkt1.opEoP, pkt1.opChannel, pkt1.opData, sampleVal(7, 0) ^ 14'h2000);
    end
    tick();
    tests++;
    if ({pkt1.opValid, busy1, ovr1, mis1} !== '0) begin
      fails++; $display("FAIL t6_after: valid=%b busy=%b ovr=%0d mis=%0d want 0", pkt1.opValid, busy1, ovr1, mis1);
    end
    waitIdle(20, "t6");
  endtask

  task automatic test_quiet_fields();
    tests++;
    if (dirty4 !== 0) begin fails++; $display("FAIL quiet_fields: got %0d dirty cycles want 0", dirty4); end
  endtask

  initial begin
    test_reset();
    test_packet();
    test_quiet_fields();
    test_overrun();
    test_missed();
    test_offset();
    test_reset_mid();
    test_single();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
